// File: rtl/wb_sdram_bridge.sv
// Wishbone-classic slave to SDRAM controller bridge with a registered request/ack handshake.
// Define WB_SDRAM_RCACHE_EN to add a 4-entry direct-mapped read cache.
module wb_sdram_bridge #(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] SDRAM_BASE = 24'h100000,
  parameter logic [ADDR_W-1:0] SDRAM_END  = 24'hffdfff,
  parameter int                TMO_CYC    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_i_dat,
  output logic [DATA_W-1:0] wb_o_dat,
  output logic              wb_ack,
  output logic              wb_err,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data_in,
  output logic [1:0]        c_addr_sel,
  output logic              c_read_req,
  output logic              c_write_req,
  input  logic              c_cack,
  input  logic              c_read_ready,
  input  logic              c_busy,
  input  logic [31:0]       c_data_out
);

  typedef enum logic [2:0] {IDLE, REQ, RDWAIT, RESP, DRAIN} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [1:0]        sel_q, sel_d;
  logic              we_q, we_d, rd_q, rd_d, wr_q, wr_d, ack_q, ack_d, err_q, err_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              in_win, accept, tmo_hit, cache_hit, fill_en, inval_en;
  logic [DATA_W-1:0] cache_rdat;
  logic              unused_in;

  assign in_win  = (wb_adr >= SDRAM_BASE) && (wb_adr <= SDRAM_END);
  // The master still holds stb during the err cycle; do not take it twice.
  assign accept  = wb_cyc && wb_stb && !err_q;
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign unused_in = &{1'b0, c_busy, c_data_out[31:DATA_W]};

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    tmo_d    = tmo_q + 8'd1;
    fill_en  = 1'b0;
    inval_en = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (accept) begin
          if (!in_win) begin
            err_d = 1'b1;
          end else begin
            adr_d    = wb_adr;
            dat_d    = wb_i_dat;
            sel_d    = wb_sel;
            we_d     = wb_we;
            inval_en = wb_we;
            if (!wb_we && cache_hit) begin
              rdat_d  = cache_rdat;
              ack_d   = 1'b1;
              state_d = RESP;
            end else begin
              rd_d    = !wb_we;
              wr_d    = wb_we;
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        if (c_cack) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          tmo_d = '0;
          if (we_q || c_read_ready) begin
            if (!wb_cyc) begin
              state_d = IDLE;
            end else begin
              state_d = RESP;
              ack_d   = 1'b1;
              if (!we_q) begin
                rdat_d  = c_data_out[DATA_W-1:0];
                fill_en = 1'b1;
              end
            end
          end else begin
            state_d = wb_cyc ? RDWAIT : DRAIN;
          end
        end else if (!wb_cyc) begin
          state_d = DRAIN;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RDWAIT: begin
        if (c_read_ready) begin
          if (!wb_cyc) begin
            state_d = IDLE;
          end else begin
            rdat_d  = c_data_out[DATA_W-1:0];
            fill_en = 1'b1;
            ack_d   = 1'b1;
            state_d = RESP;
          end
        end else if (!wb_cyc) begin
          state_d = DRAIN;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: state_d = IDLE;
      DRAIN: begin
        // Finish the abandoned controller handshake silently; the timer only guards a dead controller.
        if (rd_q || wr_q) begin
          if (c_cack) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
            if (we_q || c_read_ready) state_d = IDLE;
          end else if (tmo_hit) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = IDLE;
          end
        end else if (c_read_ready || tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef WB_SDRAM_RCACHE_EN
  logic              vld_q  [4];
  logic              vld_d  [4];
  logic [ADDR_W-3:0] tag_q  [4];
  logic [ADDR_W-3:0] tag_d  [4];
  logic [DATA_W-1:0] cdat_q [4];
  logic [DATA_W-1:0] cdat_d [4];

  assign cache_hit  = vld_q[wb_adr[1:0]] && (tag_q[wb_adr[1:0]] == wb_adr[ADDR_W-1:2]);
  assign cache_rdat = cdat_q[wb_adr[1:0]];

  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    cdat_d = cdat_q;
    if (inval_en && cache_hit) vld_d[wb_adr[1:0]] = 1'b0;
    if (fill_en) begin
      vld_d[adr_q[1:0]]  = 1'b1;
      tag_d[adr_q[1:0]]  = adr_q[ADDR_W-1:2];
      cdat_d[adr_q[1:0]] = c_data_out[DATA_W-1:0];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_line
    always_ff @(posedge i_clk) begin
      if (i_rst) vld_q[gi] <= 1'b0;
      else       vld_q[gi] <= vld_d[gi];
      tag_q[gi]  <= tag_d[gi];
      cdat_q[gi] <= cdat_d[gi];
    end
  end
`else
  logic unused_cache;
  assign cache_hit    = 1'b0;
  assign cache_rdat   = '0;
  assign unused_cache = &{1'b0, fill_en, inval_en};
`endif

  assign c_addr      = adr_q;
  assign c_data_in   = dat_q;
  assign c_addr_sel  = sel_q;
  assign c_read_req  = rd_q;
  assign c_write_req = wr_q;
  assign wb_o_dat    = rdat_q;
  assign wb_ack      = ack_q;
  assign wb_err      = err_q;

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Self-checking bench for wb_sdram_bridge: directed cases plus random transfers vs. a memory/cache model.
module tb_wb_sdram_bridge;

  localparam logic [23:0] BASE = 24'h100000;
  localparam logic [23:0] LAST = 24'hffdfff;
  localparam int          TMO  = 255;
`ifdef WB_SDRAM_RCACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [23:0] wb_adr = '0;
  logic [1:0]  wb_sel = '0;
  logic [15:0] wb_i_dat = '0;
  logic [15:0] wb_o_dat;
  logic        wb_ack, wb_err;
  logic [23:0] c_addr;
  logic [15:0] c_data_in;
  logic [1:0]  c_addr_sel;
  logic        c_read_req, c_write_req;
  logic        c_cack = 1'b0, c_read_ready = 1'b0, c_busy = 1'b0;
  logic [31:0] c_data_out = '0;

  always #5 clk = ~clk;

  wb_sdram_bridge dut (
    .i_clk(clk), .i_rst(rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_i_dat(wb_i_dat), .wb_o_dat(wb_o_dat),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .c_addr(c_addr), .c_data_in(c_data_in), .c_addr_sel(c_addr_sel),
    .c_read_req(c_read_req), .c_write_req(c_write_req),
    .c_cack(c_cack), .c_read_ready(c_read_ready), .c_busy(c_busy),
    .c_data_out(c_data_out)
  );

  int          total = 0;
  int          bad = 0;
  int          xfer_n = 0;
  logic [15:0] mem [logic [23:0]];
  logic [23:0] cm_adr [4];
  bit          cm_v [4];
  logic [15:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cack_dly: cycle of c_cack (0 or >TMO = never); rdy_dly: cycles from cack to read_ready;
  // abort_at: cycle at which wb_cyc is dropped (0 = none), followed by an out-of-window probe.
  task automatic run_xfer(input bit we, input logic [23:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, input int cack_dly, input int rdy_dly,
                          input int abort_at);
    bit          in_win, hit, timeout, aborted, fields_done;
    int          exp_ack, exp_err, exp_req, exp_resp, end_cyc, rdy_cyc, exit_cyc;
    int          ack_cyc, err_cyc, req_cyc, wrong_req, resp_cnt;
    logic [15:0] rd_val;
    in_win  = (adr >= BASE) && (adr <= LAST);
    hit     = CACHE_EN && in_win && !we && cm_v[adr[1:0]] && (cm_adr[adr[1:0]] == adr);
    if (!mem.exists(adr)) mem[adr] = 16'($urandom);
    rd_val  = mem[adr];
    timeout = (cack_dly == 0) || (cack_dly > TMO);
    rdy_cyc = cack_dly + rdy_dly;
    exit_cyc = we ? cack_dly : rdy_cyc;
    aborted = (abort_at != 0) && in_win && !hit && !timeout;
    exp_ack = -1; exp_err = -1; exp_req = 0;
    if (!in_win)      begin exp_err = 1; end_cyc = 3; end
    else if (hit)     begin exp_ack = 1; end_cyc = 3; end
    else if (timeout) begin exp_req = TMO; exp_err = TMO + 1; end_cyc = TMO + 3; end
    else if (aborted) begin exp_req = cack_dly; exp_err = exit_cyc + 2; end_cyc = exit_cyc + 4; end
    else              begin exp_req = cack_dly; exp_ack = exit_cyc + 1; end_cyc = exit_cyc + 3; end
    exp_resp = (exp_ack >= 0 ? 1 : 0) + (exp_err >= 0 ? 1 : 0);
    ack_cyc = -1; err_cyc = -1; req_cyc = 0; wrong_req = 0; resp_cnt = 0; fields_done = 0;

    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_i_dat = dat; wb_sel = sel;
    c_cack = 1'b0; c_read_ready = 1'b0;
    tick();
    for (int i = 1; i <= end_cyc; i++) begin
      if (wb_ack) begin resp_cnt++; if (ack_cyc < 0) ack_cyc = i; end
      if (wb_err) begin resp_cnt++; if (err_cyc < 0) err_cyc = i; end
      if (we ? c_write_req : c_read_req) req_cyc++;
      if (we ? c_read_req : c_write_req) wrong_req++;
      if ((c_read_req || c_write_req) && !fields_done) begin
        fields_done = 1;
        check("c_addr", 32'(c_addr), 32'(adr));
        check("c_addr_sel", 32'(c_addr_sel), 32'(sel));
        if (we) check("c_data_in", 32'(c_data_in), 32'(dat));
      end
      if (wb_ack && !we) check("rd_data", 32'(wb_o_dat), 32'(rd_val));
      if (aborted && i == abort_at) begin
        wb_cyc = 1'b0; wb_stb = 1'b0;
      end else if (aborted && i == abort_at + 1) begin
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 24'h000100;
      end
      if (wb_ack || wb_err) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
      c_cack       = in_win && !hit && !timeout && (i == cack_dly);
      c_read_ready = in_win && !hit && !timeout && !we && (i == rdy_cyc);
      c_data_out   = c_read_ready ? {16'($urandom), rd_val} : $urandom;
      tick();
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; c_cack = 1'b0; c_read_ready = 1'b0;

    check("ack_cycle", 32'(ack_cyc), 32'(exp_ack));
    check("err_cycle", 32'(err_cyc), 32'(exp_err));
    check("req_cycles", 32'(req_cyc), 32'(exp_req));
    check("wrong_req", 32'(wrong_req), 32'd0);
    check("resp_pulses", 32'(resp_cnt), 32'(exp_resp));

    if (exp_ack >= 0 && !we) begin
      last_rd = rd_val;
      cm_v[adr[1:0]] = 1'b1;
      cm_adr[adr[1:0]] = adr;
    end
    if (in_win && we && cm_v[adr[1:0]] && cm_adr[adr[1:0]] == adr) cm_v[adr[1:0]] = 1'b0;
    if (in_win && we && !timeout) mem[adr] = dat;
    tick();
    check("o_dat_hold", 32'(wb_o_dat), 32'(last_rd));
    $display("xfer %0d: we=%0b adr=%06h hit=%0b cack=%0d rdy=%0d abort=%0d ack@%0d err@%0d",
             xfer_n, we, adr, hit, cack_dly, rdy_dly, aborted ? abort_at : 0, ack_cyc, err_cyc);
    xfer_n++;
  endtask

  initial begin
    bit          r_we;
    logic [23:0] r_adr;
    int          r_cack, r_rdy, r_abort;

    for (int k = 0; k < 4; k++) begin cm_v[k] = 1'b0; cm_adr[k] = '0; end
    repeat (3) tick();
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_err", 32'(wb_err), 32'd0);
    check("rst_rreq", 32'(c_read_req), 32'd0);
    check("rst_wreq", 32'(c_write_req), 32'd0);
    check("rst_odat", 32'(wb_o_dat), 32'd0);
    check("rst_addr", 32'(c_addr), 32'd0);
    rst = 1'b0;
    tick();

    run_xfer(1'b1, 24'h100004, 16'hBEEF, 2'b11, 3, 0, 0);
    mem[24'h100010] = 16'h1234;
    run_xfer(1'b0, 24'h100010, 16'h0000, 2'b11, 2, 5, 0);
    mem[24'h100011] = 16'h5678;
    run_xfer(1'b0, 24'h100011, 16'h0000, 2'b01, 3, 0, 0);
    run_xfer(1'b0, 24'h002000, 16'h0000, 2'b11, 2, 1, 0);
    run_xfer(1'b1, 24'hffe000, 16'h1111, 2'b11, 2, 0, 0);
    run_xfer(1'b0, 24'h0fffff, 16'h0000, 2'b11, 2, 1, 0);
    run_xfer(1'b1, 24'h100000, 16'hA5A5, 2'b10, 1, 0, 0);
    run_xfer(1'b0, 24'hffdfff, 16'h0000, 2'b11, 1, 1, 0);
    run_xfer(1'b1, 24'h100008, 16'h2222, 2'b11, 0, 0, 0);
    run_xfer(1'b0, 24'h100030, 16'h0000, 2'b11, 3, 4, 2);
    run_xfer(1'b0, 24'h100020, 16'h0000, 2'b11, 2, 1, 0);
    run_xfer(1'b0, 24'h100020, 16'h0000, 2'b11, 2, 1, 0);
    run_xfer(1'b1, 24'h100020, 16'h7777, 2'b11, 2, 0, 0);
    run_xfer(1'b0, 24'h100020, 16'h0000, 2'b11, 2, 1, 0);

    // Reset in the middle of a write: request must drop on the next edge with no response.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 24'h100100; wb_i_dat = 16'h3333;
    tick();
    tick();
    check("mid_wreq_up", 32'(c_write_req), 32'd1);
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
    tick();
    check("mid_wreq_drop", 32'(c_write_req), 32'd0);
    check("mid_no_ack", 32'(wb_ack), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cm_v[k] = 1'b0;
    last_rd = '0;
    tick();

    for (int n = 0; n < 40; n++) begin
      r_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       r_adr = 24'h0ff000 + 24'($urandom_range(0, 4095));
        1:       r_adr = 24'hffe000 + 24'($urandom_range(0, 8191));
        default: r_adr = 24'h100020 + 24'($urandom_range(0, 11));
      endcase
      r_cack  = $urandom_range(1, 6);
      r_rdy   = $urandom_range(0, 4);
      r_abort = ($urandom_range(0, 5) == 0) ? $urandom_range(1, r_we ? r_cack : r_cack + r_rdy) : 0;
      run_xfer(r_we, r_adr, 16'($urandom), 2'($urandom_range(0, 3)), r_cack, r_rdy, r_abort);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
